mul_share_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one 4x4 sequential multiplier among NREQ requesters.
- Accepts operand pairs from requesters, issues a one-cycle start to the multiplier, waits for its done pulse, and returns the 8-bit product to the granted requester.
- Sits between requester blocks and the multiplier. The multiplier must be driven by the same clk and reset.

---
 rtl/mul_share_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin sequencer sharing one 4x4 sequential multiplier among NREQ requesters.
// Optional WAIT timeout/abort is enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_share_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [4*NREQ-1:0]         req_a,
  input  logic [4*NREQ-1:0]         req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [7:0]                rsp_product,
  output logic                      rsp_err,
  output logic                      mul_start,
  output logic [3:0]                mul_a,
  output logic [3:0]                mul_b,
  input  logic [7:0]                mul_product,
  input  logic                      mul_done,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id
);

  localparam int unsigned GW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("mul_share_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [3:0]      a_q, a_d;
  logic [3:0]      b_q, b_d;
  logic [7:0]      prod_q, prod_d;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  // Round-robin search starting just after the last granted requester.
  logic            win_found;
  logic [GW-1:0]   win_idx;
  logic [GW-1:0]   cand_idx;
  int unsigned     cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand     = (32'(last_grant_q) + k) % NREQ;
      cand_idx = GW'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    a_d          = a_q;
    b_d          = b_q;
    prod_d       = prod_q;
    req_ready    = '0;
`ifdef MUL_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (win_found && !reset) begin
          req_ready[win_idx] = 1'b1;
          grant_d            = win_idx;
          a_d                = req_a[{win_idx, 2'b00} +: 4];
          b_d                = req_b[{win_idx, 2'b00} +: 4];
          state_d            = StIssue;
`ifdef MUL_ARB_TIMEOUT_EN
          err_d              = 1'b0;
`endif
        end
      end
      StIssue: begin
        // Any done seen here belongs to nobody; it is deliberately dropped.
        state_d = StWait;
`ifdef MUL_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        if (mul_done) begin
          prod_d  = mul_product;
          state_d = StResp;
`ifdef MUL_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          prod_d  = 8'h00;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      StResp: begin
        last_grant_d = grant_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= GW'(NREQ - 1);
      grant_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      prod_q       <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      prod_q       <= prod_d;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == StResp) begin
      rsp_valid[grant_q] = 1'b1;
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  assign rsp_err = (state_q == StResp) && err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_product = prod_q;
  assign mul_start   = (state_q == StIssue);
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign busy        = (state_q != StIdle);
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed + randomized bench for mul_share_arbiter; the bench plays the multiplier
// and keeps a round-robin reference model of grants and products.
module tb_mul_share_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_a, req_b;
  logic [3:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_product;
  logic        rsp_err, mul_start;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_product;
  logic        mul_done;
  logic        busy;
  logic [1:0]  grant_id;

  mul_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_done(mul_done),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         lg;
  logic [3:0] rv;
  logic [3:0] ma [NREQ];
  logic [3:0] mb [NREQ];
  int         wt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    req_valid = rv;
    for (int i = 0; i < NREQ; i++) begin
      req_a[4*i +: 4] = ma[i];
      req_b[4*i +: 4] = mb[i];
    end
  endtask

  function automatic int pick(input logic [3:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(lg + k) % NREQ]) return (lg + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_mul_start"}, mul_start, 0);
    check({tag, "_mul_a"}, mul_a, 0);
    check({tag, "_mul_b"}, mul_b, 0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_rsp_product"}, rsp_product, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_req_ready"}, req_ready, 0);
  endtask

  // One complete job, starting in IDLE #1 after an edge. lat = extra WAIT cycles.
  task automatic serve(input int lat, input bit spurious, input bit drop);
    int w;
    logic [7:0] p;
    apply();
    #1;
    w = pick(rv);
    p = ma[w] * mb[w];
    check("req_ready", req_ready, 32'(1) << w);
    if (spurious) begin
      mul_done = 1'b1;
      mul_product = 8'hAA;
    end
    tick();  // ISSUE
    check("issue_start", mul_start, 1);
    check("issue_mul_a", mul_a, ma[w]);
    check("issue_mul_b", mul_b, mb[w]);
    check("issue_grant", grant_id, w);
    check("issue_busy", busy, 1);
    check("issue_ready", req_ready, 0);
    if (drop) rv[w] = 1'b0;
    apply();
    tick();  // WAIT
    mul_done = 1'b0;
    mul_product = 8'h00;
    check("wait_start", mul_start, 0);
    check("wait_rsp", rsp_valid, 0);
    repeat (lat) begin
      tick();
      check("wait_hold_rsp", rsp_valid, 0);
      check("wait_hold_a", mul_a, ma[w]);
    end
    mul_done = 1'b1;
    mul_product = p;
    tick();  // RESP
    mul_done = 1'b0;
    mul_product = 8'h3C;
    check("resp_valid", rsp_valid, 32'(1) << w);
    check("resp_product", rsp_product, p);
    check("resp_err", rsp_err, 0);
    lg = w;
    tick();  // IDLE
    check("post_busy", busy, 0);
    check("post_rsp", rsp_valid, 0);
    check("post_hold_product", rsp_product, p);
  endtask

  initial begin
    reset = 1'b1;
    rv = '0;
    mul_done = 1'b0;
    mul_product = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    apply();
    lg = NREQ - 1;
    tick();
    tick();
    check_idle_zero("reset");
    reset = 1'b0;
    tick();

    // Single request from requester 0: 3 x 5
    rv = 4'b0001; ma[0] = 4'd3; mb[0] = 4'd5;
    serve(0, 1'b0, 1'b1);

    // Spurious done while idle with no requests
    rv = '0; apply();
    mul_done = 1'b1; mul_product = 8'hFF;
    tick();
    check("idle_spur_busy", busy, 0);
    tick();
    check("idle_spur_rsp", rsp_valid, 0);
    check("idle_spur_product", rsp_product, 8'h0F);
    mul_done = 1'b0;

    // Reset while in WAIT: job aborted silently
    rv = 4'b0100; ma[2] = 4'd6; mb[2] = 4'd7; apply();
    tick();  // ISSUE
    tick();  // WAIT
    tick();
    reset = 1'b1;
    #1;
    rv = '0; apply();
    #1;
    check_idle_zero("mid_reset");
    tick();
    check("mid_reset_rsp", rsp_valid, 0);
    reset = 1'b0;
    lg = NREQ - 1;

    // All four at once, distinct operands
    ma[0] = 4'd15; mb[0] = 4'd15;
    ma[1] = 4'd7;  mb[1] = 4'd0;
    ma[2] = 4'd9;  mb[2] = 4'd6;
    ma[3] = 4'd12; mb[3] = 4'd11;
    rv = 4'b1111;
    for (int i = 0; i < 4; i++) serve(i, 1'b1, 1'b1);
    rv = 4'b0001;
    serve(1, 1'b0, 1'b1);

    // Requesters 1 and 3 held continuously
    ma[1] = 4'd2; mb[1] = 4'd8; ma[3] = 4'd13; mb[3] = 4'd4;
    rv = 4'b1010;
    for (int i = 0; i < 4; i++) serve(2, 1'b0, 1'b0);
    rv = '0; apply();
    tick();

    // Randomized jobs
    for (int n = 0; n < 40; n++) begin
      rv = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        ma[i] = 4'($urandom);
        mb[i] = 4'($urandom);
      end
      serve(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
    end
    rv = '0; apply();
    tick();

`ifdef MUL_ARB_TIMEOUT_EN
    // Multiplier never answers: abort after TIMEOUT WAIT cycles
    rv = 4'b0010; ma[1] = 4'd9; mb[1] = 4'd9; apply();
    #1;
    wt = pick(rv);
    tick();  // ISSUE
    rv = '0; apply();
    tick();  // WAIT entry
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      check("to_wait_rsp", rsp_valid, 0);
    end
    tick();
    check("to_rsp_valid", rsp_valid, 32'(1) << wt);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_product", rsp_product, 0);
    lg = wt;
    mul_done = 1'b1; mul_product = 8'h51;
    tick();
    check("to_late_busy", busy, 0);
    tick();
    check("to_late_rsp", rsp_valid, 0);
    check("to_late_product", rsp_product, 0);
    mul_done = 1'b0;
`else
    wt = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
